// File: rtl/fsm_serial_sched_if.sv
// Handshake bundle for fsm_serial_sched: two requesters, the serial FSM link and the response port.
// The slave modport is the scheduler side; master is the environment side.
interface fsm_serial_sched_if #(
  parameter int unsigned W = 8
);
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         fsm_rst_n;
  logic         fsm_in;
  logic         fsm_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, fsm_out, rsp_ready,
    output req0_ready, req1_ready, fsm_rst_n, fsm_in, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, fsm_out, rsp_ready,
    input  req0_ready, req1_ready, fsm_rst_n, fsm_in, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/fsm_serial_sched.sv
// Round-robin scheduler feeding one bit-serial FSM and collecting its W-bit response.
// Optional FSM_CLR_EN macro adds a 1-cycle FSM reset (CLR state) before every job.
module fsm_serial_sched #(
  parameter int unsigned W       = 8,
  parameter int unsigned OUT_LAG = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  fsm_serial_sched_if.slave bus
);

  localparam int unsigned CntW = $clog2(W + 4);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StShift,
    StDrain,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [W-1:0]    result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            id_q, id_d;
  logic            ptr_q, ptr_d;
  logic            gnt0, gnt1;
  logic            cap_en;
  logic [CntW:0]   cap_diff;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      word_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      id_q     <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

  // cnt_q runs through SHIFT and DRAIN; a negative difference means no bit is due yet.
  assign cap_diff = {1'b0, cnt_q} - (CntW + 1)'(OUT_LAG);

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    result_d      = result_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    ptr_d         = ptr_q;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    cap_en        = 1'b0;
    bus.fsm_in    = 1'b0;
    bus.fsm_rst_n = sys_rst_n;
    bus.rsp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sys_rst_n) begin
          gnt0 = bus.req0_valid && (!ptr_q || !bus.req1_valid);
          gnt1 = bus.req1_valid && !gnt0;
        end
        if (gnt0 || gnt1) begin
          word_d = gnt1 ? bus.req1_data : bus.req0_data;
          id_d   = gnt1;
          cnt_d  = '0;
`ifdef FSM_CLR_EN
          state_d = StClr;
`else
          state_d = StShift;
`endif
        end
      end
      StClr: begin
`ifdef FSM_CLR_EN
        bus.fsm_rst_n = 1'b0;
`endif
        state_d = StShift;
      end
      StShift: begin
        bus.fsm_in = word_q[0];
        word_d     = word_q >> 1;
        cap_en     = 1'b1;
        cnt_d      = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = (OUT_LAG == 0) ? StResp : StDrain;
        end
      end
      StDrain: begin
        cap_en = 1'b1;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W + OUT_LAG - 1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = StIdle;
          ptr_d   = ~id_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cap_en && !cap_diff[CntW]) begin
      for (int k = 0; k < int'(W); k++) begin
        if (cap_diff[CntW-1:0] == CntW'(k)) begin
          result_d[k] = bus.fsm_out;
        end
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = result_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fsm_serial_sched.sv
// Randomized bench for fsm_serial_sched; the FSM stand-in echoes fsm_in one clock later.
// A job-level model predicts grants, serial bits, response timing and data per cycle.
module tb_fsm_serial_sched;

  localparam int unsigned W       = 8;
  localparam int unsigned OUT_LAG = 1;
`ifdef FSM_CLR_EN
  localparam int unsigned Off = 1;
`else
  localparam int unsigned Off = 0;
`endif

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic fsm_q;

  always #5 clk = ~clk;

  fsm_serial_sched_if #(.W(W)) bus ();

  fsm_serial_sched #(
    .W      (W),
    .OUT_LAG(OUT_LAG)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  always @(posedge clk) begin
    if (!bus.fsm_rst_n) fsm_q <= 1'b0;
    else                fsm_q <= bus.fsm_in;
  end
  assign bus.fsm_out = fsm_q;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int gcyc = 0;
  bit job = 1'b0;
  bit prev_rst = 1'b0;
  bit ptr = 1'b0;
  bit cur_id = 1'b0;
  bit g0, g1;
  logic [W-1:0] cur_word;
  bit p0v = 1'b0, p1v = 1'b0;
  logic [W-1:0] p0d = '0, p1d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check #1 later, then advance the model past the next posedge.
  task automatic step(input bit rst_n, input bit rr);
    bit pv[2];
    bit win;
    bit exp_in, exp_frst, exp_rv;
    int t;
    @(negedge clk);
    sys_rst_n      = rst_n;
    bus.req0_valid = p0v;
    bus.req0_data  = p0d;
    bus.req1_valid = p1v;
    bus.req1_data  = p1d;
    bus.rsp_ready  = rr;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst_n) begin
      check("rst_req0_ready", 32'(bus.req0_ready), 0);
      check("rst_req1_ready", 32'(bus.req1_ready), 0);
      check("rst_fsm_rst_n", 32'(bus.fsm_rst_n), 0);
      if (prev_rst) begin
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_fsm_in", 32'(bus.fsm_in), 0);
      end
      job = 1'b0;
      ptr = 1'b0;
    end else if (!job) begin
      pv[0] = p0v;
      pv[1] = p1v;
      if (pv[ptr]) begin
        win = ptr;
        g0 = !win; g1 = win;
      end else if (pv[!ptr]) begin
        win = !ptr;
        g0 = !win; g1 = win;
      end
      check("idle_req0_ready", 32'(bus.req0_ready), 32'(g0));
      check("idle_req1_ready", 32'(bus.req1_ready), 32'(g1));
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_rsp_valid", 32'(bus.rsp_valid), 0);
      check("idle_fsm_in", 32'(bus.fsm_in), 0);
      check("idle_fsm_rst_n", 32'(bus.fsm_rst_n), 1);
      if (g0 || g1) begin
        job      = 1'b1;
        gcyc     = cyc;
        cur_id   = g1;
        cur_word = g1 ? p1d : p0d;
      end
    end else begin
      t        = cyc - gcyc;
      exp_frst = !(Off == 1 && t == 1);
      exp_in   = 1'b0;
      if (t > int'(Off) && t <= int'(Off + W)) exp_in = cur_word[t - int'(Off) - 1];
      exp_rv = (t >= int'(Off + W + OUT_LAG + 1));
      check("job_req0_ready", 32'(bus.req0_ready), 0);
      check("job_req1_ready", 32'(bus.req1_ready), 0);
      check("job_busy", 32'(bus.busy), 1);
      check("job_fsm_in", 32'(bus.fsm_in), 32'(exp_in));
      check("job_fsm_rst_n", 32'(bus.fsm_rst_n), 32'(exp_frst));
      check("job_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check("rsp_id", 32'(bus.rsp_id), 32'(cur_id));
        check("rsp_data", 32'(bus.rsp_data), 32'(cur_word));
        if (rr) begin
          job = 1'b0;
          ptr = !cur_id;
        end
      end
    end
    prev_rst = !rst_n;
    cyc++;
    if (g0) p0v = 1'b0;
    if (g1) p1v = 1'b0;
  endtask

  localparam int unsigned JobLen = Off + W + OUT_LAG + 2;

  initial begin
    bit rst_n, rr;
    // Reset for two clocks
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Single job on req0
    p0v = 1'b1;
    p0d = 8'b0110_1010;
    repeat (JobLen + 2) step(1'b1, 1'b1);

    // Contention from a fresh pointer: req0 first, then req1
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    p0v = 1'b1; p0d = 8'hA5;
    p1v = 1'b1; p1d = 8'h3C;
    repeat (2 * JobLen + 3) step(1'b1, 1'b1);

    // Response back-pressure with req1 pending
    p0v = 1'b1; p0d = W'($urandom);
    step(1'b1, 1'b1);
    repeat (Off + W + OUT_LAG) step(1'b1, 1'b1);
    p1v = 1'b1; p1d = W'($urandom);
    repeat (5) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (JobLen + 2) step(1'b1, 1'b1);

    // Reset while bit 3 is on fsm_in, then a clean job on req1
    p0v = 1'b1; p0d = W'($urandom);
    step(1'b1, 1'b1);
    repeat (Off + 3) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    p0v = 1'b0;
    p1v = 1'b1; p1d = W'($urandom);
    repeat (JobLen + 2) step(1'b1, 1'b1);

    // Random traffic with drops, back-pressure and occasional resets
    repeat (1500) begin
      if (!p0v && ($urandom % 3) == 0) begin
        p0v = 1'b1; p0d = W'($urandom);
      end else if (p0v && ($urandom % 10) == 0) begin
        p0v = 1'b0;
      end
      if (!p1v && ($urandom % 3) == 0) begin
        p1v = 1'b1; p1d = W'($urandom);
      end else if (p1v && ($urandom % 10) == 0) begin
        p1v = 1'b0;
      end
      rr    = ($urandom % 4) != 0;
      rst_n = ($urandom % 250) != 0;
      step(rst_n, rr);
    end
    p0v = 1'b0;
    p1v = 1'b0;
    repeat (JobLen + 2) step(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
